mul_share_arb: RTL and testbench

// - Shares one N-cycle-occupancy multiplier (mul) among p_nreqs requesters over val/rdy.
// - Round-robin arbitration; one operation in flight at a time; each response is routed back to its issuer.
// - Sits between the CGRA processing elements (PEs) and a single multiplier tile. The mul instance is internal.

---
 rtl/mul_share_pkg.sv | 27 ++
 rtl/mul_share_arb_mul.sv | 73 +++++++
 rtl/mul_share_arb_rr_arb.sv | 47 ++++
 rtl/mul_share_arb.sv | 127 ++++++++++++
 tb/tb_mul_share_arb.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_share_pkg.sv
// mul_share_pkg
// Shared types and constants for the shared-multiplier arbiter (mul_share_arb)
// and its sub-blocks (rr_arb, mul).
//   arb_state_e  : arbiter FSM states (IDLE, BUSY)
//   mul_state_e  : multiplier occupancy FSM states
//   idx_width()  : width of an index into n items, never less than 1
//   STAT_WIDTH   : width of the optional completed-operation counter
package mul_share_pkg;

    localparam int STAT_WIDTH = 16;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_CALC = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mul_share_arb_mul.sv
// mul
// Unsigned multiplier with p_ncycles occupancy behind val/rdy. The product is
// captured at acceptance and presented p_ncycles cycles after the accepting
// cycle; it is held stable until the response is taken. A new request is
// accepted in the same cycle the pending response is taken, so ops can run
// back to back with no bubble.
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   req_val/req_rdy/req_msg    operand pair {b, a} (a = low half)
//   resp_val/resp_rdy/resp_msg full 2*p_width product
module mul
    import mul_share_pkg::*;
#(
    parameter int p_width   = 4,
    parameter int p_ncycles = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_val,
    output logic                 req_rdy,
    input  logic [2*p_width-1:0] req_msg,
    output logic                 resp_val,
    input  logic                 resp_rdy,
    output logic [2*p_width-1:0] resp_msg
);

    localparam int MW = 2 * p_width;
    localparam int CW = idx_width(p_ncycles + 1);

    mul_state_e    state, state_next;
    logic [CW-1:0] cnt;
    logic [MW-1:0] prod;
    logic [MW-1:0] op_a, op_b;
    logic          req_go, resp_go;

    assign op_a     = {{p_width{1'b0}}, req_msg[p_width-1:0]};
    assign op_b     = {{p_width{1'b0}}, req_msg[MW-1:p_width]};
    assign resp_val = (state == MUL_DONE);
    assign resp_msg = prod;
    assign resp_go  = resp_val && resp_rdy;
    assign req_rdy  = (state == MUL_IDLE) || resp_go;
    assign req_go   = req_val && req_rdy;

    always_comb begin
        state_next = state;
        case (state)
            MUL_IDLE: if (req_go) state_next = (p_ncycles == 1) ? MUL_DONE : MUL_CALC;
            MUL_CALC: if (cnt == CW'(p_ncycles - 1)) state_next = MUL_DONE;
            MUL_DONE: begin
                if (req_go)       state_next = (p_ncycles == 1) ? MUL_DONE : MUL_CALC;
                else if (resp_go) state_next = MUL_IDLE;
            end
            default:  state_next = MUL_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= MUL_IDLE;
            cnt   <= '0;
            prod  <= '0;
        end else begin
            state <= state_next;
            if (req_go) begin
                cnt  <= CW'(1);
                prod <= op_a * op_b;
            end else if (state == MUL_CALC) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul_share_arb_rr_arb.sv
// rr_arb
// Combinational round-robin picker: grants the first valid requester at or
// after rr_ptr, wrapping modulo p_nreqs. The pointer register lives in the
// caller; this block only searches.
// Ports:
//   valid     in   p_nreqs  request valid vector
//   rr_ptr    in   IW       highest-priority requester index
//   en        in   1        arbitration allowed this cycle
//   grant     out  p_nreqs  one-hot grant (zero when en=0 or nothing valid)
//   grant_idx out  IW       encoded index of grant
//   any_grant out  1        a grant was issued
module rr_arb
    import mul_share_pkg::*;
#(
    parameter int p_nreqs = 4,
    localparam int IW = idx_width(p_nreqs)
) (
    input  logic [p_nreqs-1:0] valid,
    input  logic [IW-1:0]      rr_ptr,
    input  logic               en,
    output logic [p_nreqs-1:0] grant,
    output logic [IW-1:0]      grant_idx,
    output logic               any_grant
);

    int            slot;
    logic [IW-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        slot      = 0;
        cand      = '0;
        for (int k = 0; k < p_nreqs; k++) begin
            slot = int'(rr_ptr) + k;
            if (slot >= p_nreqs) slot = slot - p_nreqs;
            cand = IW'(slot);
            if (en && !any_grant && valid[cand]) begin
                any_grant   = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mul_share_arb.sv
// mul_share_arb
// Shares one internal p_ncycles-occupancy multiplier among p_nreqs requesters.
// Round-robin arbitration, one op in flight, response routed to its issuer.
// In the cycle a response is taken, arbitration runs again so a new op can be
// issued with no bubble (pipelined handoff).
// Optional feature: define MUL_SHARE_STATS_EN to add the saturating stat_ops
// counter of completed operations.
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   req_val     in   p_nreqs            per-requester request valid
//   req_rdy     out  p_nreqs            one-hot or zero request ready
//   req_msg     in   p_nreqs*2*p_width  requester i at [i*2*p_width +: 2*p_width]
//   resp_val    out  p_nreqs            one-hot or zero response valid
//   resp_rdy    in   p_nreqs            per-requester response ready
//   resp_msg    out  2*p_width          product, qualified by resp_val[i]
//   stat_ops    out  16                 completed ops (MUL_SHARE_STATS_EN only)
// Handshake: a transfer happens in a cycle where val and rdy are both high;
// a valid response is held unchanged until its ready is seen.
module mul_share_arb
    import mul_share_pkg::*;
#(
    parameter int p_width   = 4,
    parameter int p_ncycles = 3,
    parameter int p_nreqs   = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [p_nreqs-1:0]           req_val,
    output logic [p_nreqs-1:0]           req_rdy,
    input  logic [p_nreqs*2*p_width-1:0] req_msg,
    output logic [p_nreqs-1:0]           resp_val,
    input  logic [p_nreqs-1:0]           resp_rdy,
    output logic [2*p_width-1:0]         resp_msg
`ifdef MUL_SHARE_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0]        stat_ops
`endif
);

    localparam int IW = idx_width(p_nreqs);
    localparam int MW = 2 * p_width;

    arb_state_e    state, state_next;
    logic [IW-1:0] rr_ptr, owner;

    logic               arb_en, any_grant;
    logic [p_nreqs-1:0] grant;
    logic [IW-1:0]      grant_idx;

    logic          mul_req_val, mul_req_rdy, mul_resp_val, mul_resp_rdy;
    logic [MW-1:0] mul_req_msg, mul_resp_msg;
    logic          req_go, resp_go;

    // Response path is only live while an op is owned.
    assign mul_resp_rdy = (state == BUSY) && resp_rdy[owner];
    assign resp_go      = mul_resp_val && mul_resp_rdy;

    // Arbitrate when idle, or in the cycle the pending response is taken.
    // rr_ptr already moved past the current owner at its grant.
    assign arb_en = (state == IDLE) || resp_go;

    rr_arb #(.p_nreqs(p_nreqs)) u_rr_arb (
        .valid     (req_val),
        .rr_ptr    (rr_ptr),
        .en        (arb_en),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    assign mul_req_val = any_grant;
    assign mul_req_msg = req_msg[grant_idx*MW +: MW];
    assign req_rdy     = mul_req_rdy ? grant : '0;
    assign req_go      = any_grant && mul_req_rdy;
    assign resp_msg    = mul_resp_msg;

    always_comb begin
        resp_val = '0;
        if (state == BUSY) resp_val[owner] = mul_resp_val;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_go) state_next = BUSY;
            BUSY:    if (resp_go && !req_go) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            rr_ptr <= '0;
            owner  <= '0;
        end else begin
            state <= state_next;
            if (req_go) begin
                owner  <= grant_idx;
                rr_ptr <= (grant_idx == IW'(p_nreqs - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    mul #(.p_width(p_width), .p_ncycles(p_ncycles)) u_mul (
        .clk      (clk),
        .reset    (reset),
        .req_val  (mul_req_val),
        .req_rdy  (mul_req_rdy),
        .req_msg  (mul_req_msg),
        .resp_val (mul_resp_val),
        .resp_rdy (mul_resp_rdy),
        .resp_msg (mul_resp_msg)
    );

`ifdef MUL_SHARE_STATS_EN
    logic [STAT_WIDTH-1:0] stat_ops_q;

    always_ff @(posedge clk) begin
        if (reset)                          stat_ops_q <= '0;
        else if (resp_go && stat_ops_q != '1) stat_ops_q <= stat_ops_q + 1'b1;
    end

    assign stat_ops = stat_ops_q;
`endif

endmodule

// File: tb/tb_mul_share_arb.sv
// tb_mul_share_arb
// Self-checking bench for mul_share_arb (p_width=4, p_ncycles=3, p_nreqs=4).
// A negedge monitor pushes {requester, product} on every request handshake
// and pops/compares on every response handshake; scenario tasks check
// grant order, timing, back-pressure, pointer wrap and reset behaviour.
// Define MUL_SHARE_STATS_EN to also exercise stat_ops.
module tb_mul_share_arb;

    localparam int NR = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_val, req_rdy, resp_val, resp_rdy;
    logic [31:0] req_msg;
    logic [7:0]  resp_msg;
`ifdef MUL_SHARE_STATS_EN
    logic [15:0] stat_ops;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [9:0] exp_q[$];
    logic [9:0] mon_exp, mon_got;

    always #5 clk = ~clk;

    mul_share_arb #(.p_width(4), .p_ncycles(3), .p_nreqs(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .req_val  (req_val),
        .req_rdy  (req_rdy),
        .req_msg  (req_msg),
        .resp_val (resp_val),
        .resp_rdy (resp_rdy),
        .resp_msg (resp_msg)
`ifdef MUL_SHARE_STATS_EN
        ,
        .stat_ops (stat_ops)
`endif
    );

    function automatic logic [7:0] model_mul(input logic [7:0] m);
        logic [7:0] a, b;
        a = {4'h0, m[3:0]};
        b = {4'h0, m[7:4]};
        return a * b;
    endfunction

    function automatic logic [1:0] enc(input logic [3:0] oh);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < NR; i++) if (oh[i]) r = 2'(i);
        return r;
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!reset) begin
            n_checks++;
            if (!$onehot0(resp_val)) begin
                n_errors++;
                $display("FAIL resp_onehot: resp_val=%b required one-hot or zero", resp_val);
            end
            if (|(resp_val & resp_rdy)) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL resp_unexpected: resp_val=%b msg=%h required no response", resp_val, resp_msg);
                end else begin
                    mon_exp = exp_q.pop_front();
                    mon_got = {enc(resp_val), resp_msg};
                    if (mon_got !== mon_exp) begin
                        n_errors++;
                        $display("FAIL resp_data: got req%0d msg=%h required req%0d msg=%h",
                                 mon_got[9:8], mon_got[7:0], mon_exp[9:8], mon_exp[7:0]);
                    end
                end
            end
            for (int i = 0; i < NR; i++)
                if (req_val[i] && req_rdy[i])
                    exp_q.push_back({2'(i), model_mul(req_msg[i*8 +: 8])});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || resp_val != 4'b0) && k < 40) begin
            tick();
            k++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        req_val  = '0;
        req_msg  = '0;
        resp_rdy = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (req_rdy !== 4'b0) begin n_errors++; $display("FAIL reset_req_rdy: got %b required 0000", req_rdy); end
        n_checks++;
        if (resp_val !== 4'b0) begin n_errors++; $display("FAIL reset_resp_val: got %b required 0000", resp_val); end
        n_checks++;
        if (resp_msg !== 8'h00) begin n_errors++; $display("FAIL reset_resp_msg: got %h required 00", resp_msg); end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_rotation();
        logic [3:0] exp_oh;
        int last, ngr;
        exp_oh = 4'b0001;
        last   = -1;
        ngr    = 0;
        for (int i = 0; i < NR; i++) req_msg[i*8 +: 8] = 8'($urandom_range(0, 255));
        req_val = '1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (|req_rdy) begin
                n_checks++;
                if (req_rdy !== exp_oh) begin
                    n_errors++;
                    $display("FAIL rot_grant: got %b required %b", req_rdy, exp_oh);
                end
                if (last >= 0) begin
                    n_checks++;
                    if (c - last != 3) begin
                        n_errors++;
                        $display("FAIL rot_gap: got %0d cycles required 3", c - last);
                    end
                end
                last   = c;
                exp_oh = {exp_oh[2:0], exp_oh[3]};
                ngr++;
            end
            tick();
            for (int i = 0; i < NR; i++) req_msg[i*8 +: 8] = 8'($urandom_range(0, 255));
        end
        req_val = '0;
        n_checks++;
        if (ngr != 5) begin n_errors++; $display("FAIL rot_count: got %0d grants required 5", ngr); end
        drain();
    endtask

    task automatic test_single();
        req_msg[2*8 +: 8] = 8'h53;
        req_val = 4'b0100;
        @(negedge clk);
        n_checks++;
        if (req_rdy !== 4'b0100) begin n_errors++; $display("FAIL single_grant: got %b required 0100", req_rdy); end
        tick();
        req_val = '0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (k < 3 && resp_val !== 4'b0) begin
                n_errors++;
                $display("FAIL single_early: cycle %0d resp_val=%b required 0000", k, resp_val);
            end
            if (k == 3 && (resp_val !== 4'b0100 || resp_msg !== 8'h0F)) begin
                n_errors++;
                $display("FAIL single_resp: got %b/%h required 0100/0f", resp_val, resp_msg);
            end
        end
        tick();
        drain();
    endtask

    task automatic test_backpressure();
        int k;
        resp_rdy = 4'b1101;
        req_msg[1*8 +: 8] = 8'hFF;
        req_val = 4'b0010;
        @(negedge clk);
        n_checks++;
        if (req_rdy !== 4'b0010) begin n_errors++; $display("FAIL bp_grant: got %b required 0010", req_rdy); end
        tick();
        req_val = 4'b1000;
        req_msg[3*8 +: 8] = 8'h72;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (resp_val == 4'b0 && k < 10);
        n_checks++;
        if (resp_val !== 4'b0010) begin n_errors++; $display("FAIL bp_resp: got %b required 0010", resp_val); end
        for (int c = 0; c < 10; c++) begin
            tick();
            @(negedge clk);
            n_checks++;
            if (resp_val !== 4'b0010 || resp_msg !== 8'hE1 || req_rdy !== 4'b0) begin
                n_errors++;
                $display("FAIL bp_hold: resp_val=%b msg=%h req_rdy=%b required 0010/e1/0000",
                         resp_val, resp_msg, req_rdy);
            end
        end
        tick();
        resp_rdy = '1;
        @(negedge clk);
        n_checks++;
        if (req_rdy !== 4'b1000 || resp_val !== 4'b0010) begin
            n_errors++;
            $display("FAIL bp_handoff: req_rdy=%b resp_val=%b required 1000/0010", req_rdy, resp_val);
        end
        tick();
        req_val = '0;
        drain();
    endtask

    task automatic test_wrap();
        int k;
        req_msg[3*8 +: 8] = 8'($urandom_range(0, 255));
        req_val = 4'b1000;
        @(negedge clk);
        n_checks++;
        if (req_rdy !== 4'b1000) begin n_errors++; $display("FAIL wrap_first: got %b required 1000", req_rdy); end
        tick();
        req_val = '0;
        drain();
        req_msg[0*8 +: 8] = 8'($urandom_range(0, 255));
        req_msg[3*8 +: 8] = 8'($urandom_range(0, 255));
        req_val = 4'b1001;
        @(negedge clk);
        n_checks++;
        if (req_rdy !== 4'b0001) begin n_errors++; $display("FAIL wrap_zero: got %b required 0001", req_rdy); end
        tick();
        req_val = 4'b1000;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (req_rdy == 4'b0 && k < 10);
        n_checks++;
        if (req_rdy !== 4'b1000) begin n_errors++; $display("FAIL wrap_three: got %b required 1000", req_rdy); end
        tick();
        req_val = '0;
        drain();
    endtask

    task automatic test_reset_mid();
        req_msg[0*8 +: 8] = 8'($urandom_range(0, 255));
        req_val = 4'b0001;
        @(negedge clk);
        n_checks++;
        if (req_rdy !== 4'b0001) begin n_errors++; $display("FAIL rmid_grant: got %b required 0001", req_rdy); end
        tick();
        req_val = '0;
        tick();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (req_rdy !== 4'b0 || resp_val !== 4'b0 || resp_msg !== 8'h00) begin
            n_errors++;
            $display("FAIL rmid_outputs: req_rdy=%b resp_val=%b msg=%h required all zero",
                     req_rdy, resp_val, resp_msg);
        end
        exp_q.delete();
        tick();
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if (resp_val !== 4'b0) begin n_errors++; $display("FAIL rmid_noresp: got %b required 0000", resp_val); end
        end
        tick();
        req_msg[0*8 +: 8] = 8'h9C;
        req_msg[3*8 +: 8] = 8'h47;
        req_val = 4'b1001;
        @(negedge clk);
        n_checks++;
        if (req_rdy !== 4'b0001) begin n_errors++; $display("FAIL rmid_prio: got %b required 0001", req_rdy); end
        tick();
        req_val = '0;
        drain();
    endtask

`ifdef MUL_SHARE_STATS_EN
    task automatic do_op(input int i, input logic [7:0] m);
        int k;
        req_msg[i*8 +: 8] = m;
        req_val = 4'(1 << i);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (req_rdy[i] !== 1'b1 && k < 20);
        n_checks++;
        if (req_rdy[i] !== 1'b1) begin n_errors++; $display("FAIL op_grant: req%0d got %b required grant", i, req_rdy); end
        tick();
        req_val = '0;
        drain();
    endtask

    task automatic test_stats();
        for (int n = 0; n < 4; n++) do_op(n, 8'($urandom_range(0, 255)));
        n_checks++;
        if (stat_ops !== 16'd5) begin n_errors++; $display("FAIL stat_count: got %0d required 5", stat_ops); end
        force dut.stat_ops_q = 16'hFFFF;
        tick();
        release dut.stat_ops_q;
        do_op(2, 8'h77);
        tick();
        n_checks++;
        if (stat_ops !== 16'hFFFF) begin n_errors++; $display("FAIL stat_sat: got %h required ffff", stat_ops); end
    endtask
`endif

    initial begin
        reset    = 1'b1;
        req_val  = '0;
        req_msg  = '0;
        resp_rdy = '1;
        test_reset();
        test_rotation();
        test_single();
        test_backpressure();
        test_wrap();
        test_reset_mid();
`ifdef MUL_SHARE_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + exp_q.size());
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
